// File: rtl/alu_acc_pkg.sv
// Shared opcode and state definitions for the
// accumulator ALU and its register file.
package alu_acc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_ADD   = 4'd2,
    OP_ADC   = 4'd3,
    OP_SUB   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NOT   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_MUL   = 4'd11,
    OP_STORE = 4'd12
  } op_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_acc_regfile.sv
// Register file: one async read port, a STORE write port
// and an external write port; STORE wins on address clash.
module alu_acc_regfile #(
  parameter int DATA_W    = 8,
  parameter int REG_DEPTH = 8,
  localparam int ADDR_W   = $clog2(REG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_st_we,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_data
);

  logic [DATA_W-1:0] r_mem [REG_DEPTH];

  assign o_rd_data = r_mem[i_rd_addr];

  // STORE is written last so it overrides the external port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_ext_we) begin
        r_mem[i_ext_addr] <= i_ext_data;
      end
      if (i_st_we) begin
        r_mem[i_st_addr] <= i_st_data;
      end
    end
  end

endmodule

// File: rtl/alu_acc_param.sv
// Accumulator ALU with register file and a multi-cycle
// shift-add multiplier.
module alu_acc_param
  import alu_acc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int REG_DEPTH = 8,
  localparam int ADDR_W   = $clog2(REG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_op_valid,
  input  logic [3:0]        i_operation_code,
  input  logic [ADDR_W-1:0] i_register_file_mux_addr,
  input  logic [DATA_W-1:0] i_register_file,
  input  logic              i_register_file_ce,
  input  logic [ADDR_W-1:0] i_reg_wr_addr,
  input  logic [DATA_W-1:0] i_data_memory,
  input  logic              i_data_memory_read_enable,
  input  logic [DATA_W-1:0] i_direct_data,
  input  logic              i_direct_load,
  output logic              o_ready,
  output logic              o_done,
  output logic [DATA_W-1:0] o_alu,
  output logic [DATA_W-1:0] o_alu_argument,
  output logic [DATA_W-1:0] o_acumulator,
  output logic [DATA_W-1:0] o_mul_high,
  output logic              o_carry,
  output logic              o_zero
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PW    = 2 * DATA_W;

  state_e              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_mul_high;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [PW-1:0]       r_prod;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic                r_zero;
  logic                r_done;

  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_b;
  logic                w_ready;
  logic                w_accept;
  op_e                 w_op;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_res;
  logic                w_cout;
  logic                w_wr_acc;
  logic                w_wr_carry;
  logic                w_store;
  logic [PW-1:0]       w_addend;
  logic [PW-1:0]       w_prod_nxt;
  logic                w_mul_last;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = i_op_valid && w_ready;
  assign w_op     = op_e'(i_operation_code);
  assign w_store  = w_accept && (w_op == OP_STORE);

  alu_acc_regfile #(
    .DATA_W    (DATA_W),
    .REG_DEPTH (REG_DEPTH)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_addr  (i_register_file_mux_addr),
    .o_rd_data  (w_rd_data),
    .i_st_we    (w_store),
    .i_st_addr  (i_register_file_mux_addr),
    .i_st_data  (r_acc),
    .i_ext_we   (i_register_file_ce),
    .i_ext_addr (i_reg_wr_addr),
    .i_ext_data (i_register_file)
  );

  always_comb begin
    if (i_direct_load) begin
      w_b = i_direct_data;
    end else if (i_data_memory_read_enable) begin
      w_b = i_data_memory;
    end else begin
      w_b = w_rd_data;
    end
  end

  always_comb begin
    w_sum      = '0;
    w_res      = '0;
    w_cout     = 1'b0;
    w_wr_acc   = 1'b0;
    w_wr_carry = 1'b0;
    unique case (w_op)
      OP_LOAD: begin
        w_res    = w_b;
        w_wr_acc = 1'b1;
      end
      OP_ADD: begin
        w_sum      = {1'b0, r_acc} + {1'b0, w_b};
        w_res      = w_sum[DATA_W-1:0];
        w_cout     = w_sum[DATA_W];
        w_wr_acc   = 1'b1;
        w_wr_carry = 1'b1;
      end
      OP_ADC: begin
        w_sum      = {1'b0, r_acc} + {1'b0, w_b}
                   + {{DATA_W{1'b0}}, r_carry};
        w_res      = w_sum[DATA_W-1:0];
        w_cout     = w_sum[DATA_W];
        w_wr_acc   = 1'b1;
        w_wr_carry = 1'b1;
      end
      OP_SUB: begin
        w_sum      = {1'b0, r_acc} - {1'b0, w_b};
        w_res      = w_sum[DATA_W-1:0];
        w_cout     = w_sum[DATA_W];
        w_wr_acc   = 1'b1;
        w_wr_carry = 1'b1;
      end
      OP_AND: begin
        w_res    = r_acc & w_b;
        w_wr_acc = 1'b1;
      end
      OP_OR: begin
        w_res    = r_acc | w_b;
        w_wr_acc = 1'b1;
      end
      OP_XOR: begin
        w_res    = r_acc ^ w_b;
        w_wr_acc = 1'b1;
      end
      OP_NOT: begin
        w_res    = ~r_acc;
        w_wr_acc = 1'b1;
      end
      OP_SHL: begin
        w_res      = {r_acc[DATA_W-2:0], 1'b0};
        w_cout     = r_acc[DATA_W-1];
        w_wr_acc   = 1'b1;
        w_wr_carry = 1'b1;
      end
      OP_SHR: begin
        w_res      = {1'b0, r_acc[DATA_W-1:1]};
        w_cout     = r_acc[0];
        w_wr_acc   = 1'b1;
        w_wr_carry = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // One multiplier bit per cycle, weighted by the step count.
  assign w_addend   = r_mplier[0]
                    ? ({{DATA_W{1'b0}}, r_mcand} << r_cnt)
                    : '0;
  assign w_prod_nxt = r_prod + w_addend;
  assign w_mul_last = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mul_high <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state  <= S_MUL_RUN;
              r_mcand  <= r_acc;
              r_mplier <= w_b;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else begin
              r_done <= 1'b1;
              if (w_wr_acc) begin
                r_acc  <= w_res;
                r_zero <= (w_res == '0);
              end
              if (w_wr_carry) begin
                r_carry <= w_cout;
              end
            end
          end
        end
        S_MUL_RUN: begin
          r_prod   <= w_prod_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_state    <= S_IDLE;
            r_acc      <= w_prod_nxt[DATA_W-1:0];
            r_mul_high <= w_prod_nxt[PW-1:DATA_W];
            r_carry    <= 1'b0;
            r_zero     <= (w_prod_nxt[DATA_W-1:0] == '0);
            r_done     <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready        = w_ready;
  assign o_done         = r_done;
  assign o_alu          = w_ready ? w_res : '0;
  assign o_alu_argument = w_b;
  assign o_acumulator   = r_acc;
  assign o_mul_high     = r_mul_high;
  assign o_carry        = r_carry;
  assign o_zero         = r_zero;

endmodule

// File: tb/tb_alu_acc_param.sv
// Randomised self-checking bench for alu_acc_param
// against an arithmetic reference model.
module tb_alu_acc_param;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic [3:0]   opc;
  logic [A-1:0] mux_addr;
  logic [W-1:0] rf_data;
  logic         rf_ce;
  logic [A-1:0] wr_addr;
  logic [W-1:0] mem;
  logic         mem_en;
  logic [W-1:0] imm;
  logic         dl;
  logic         ready;
  logic         done;
  logic [W-1:0] alu;
  logic [W-1:0] arg;
  logic [W-1:0] acc;
  logic [W-1:0] mh;
  logic         carry;
  logic         zero;

  int n_chk  = 0;
  int n_pass = 0;

  int m_acc, m_carry, m_zero, m_mh;
  int m_reg [D];

  always #5 clk = ~clk;

  alu_acc_param #(.DATA_W(W), .REG_DEPTH(D)) dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .i_op_valid                (op_valid),
    .i_operation_code          (opc),
    .i_register_file_mux_addr  (mux_addr),
    .i_register_file           (rf_data),
    .i_register_file_ce        (rf_ce),
    .i_reg_wr_addr             (wr_addr),
    .i_data_memory             (mem),
    .i_data_memory_read_enable (mem_en),
    .i_direct_data             (imm),
    .i_direct_load             (dl),
    .o_ready                   (ready),
    .o_done                    (done),
    .o_alu                     (alu),
    .o_alu_argument            (arg),
    .o_acumulator              (acc),
    .o_mul_high                (mh),
    .o_carry                   (carry),
    .o_zero                    (zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int ref_b(int d, int me, int im,
                               int mm, int ad);
    if (d != 0) return im;
    if (me != 0) return mm;
    return m_reg[ad];
  endfunction

  function automatic int ref_alu(int o, int b);
    case (o)
      1:  return b;
      2:  return (m_acc + b) & M;
      3:  return (m_acc + b + m_carry) & M;
      4:  return (m_acc - b) & M;
      5:  return m_acc & b;
      6:  return m_acc | b;
      7:  return m_acc ^ b;
      8:  return (~m_acc) & M;
      9:  return (m_acc * 2) & M;
      10: return m_acc / 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_carry = 0; m_zero = 0; m_mh = 0;
    for (int i = 0; i < D; i++) m_reg[i] = 0;
  endtask

  task automatic idle_inputs();
    op_valid = 0; opc = 0; mux_addr = 0; rf_data = 0;
    rf_ce = 0; wr_addr = 0; mem = 0; mem_en = 0;
    imm = 0; dl = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " acc"}, acc, m_acc);
    chk({tag, " carry"}, carry, m_carry);
    chk({tag, " zero"}, zero, m_zero);
    chk({tag, " mulh"}, mh, m_mh);
  endtask

  task automatic do_op(int o, int d, int me, int im, int mm,
                       int ad, int ce, int wa, int wd, int hold);
    int b, old, s, p;
    @(negedge clk);
    op_valid = 1; opc = 4'(o); dl = d[0]; mem_en = me[0];
    imm = W'(im); mem = W'(mm); mux_addr = A'(ad);
    rf_ce = ce[0]; wr_addr = A'(wa); rf_data = W'(wd);
    #1;
    b = ref_b(d, me, im, mm, ad);
    chk("arg", arg, b);
    chk("alu", alu, ref_alu(o, b));
    chk("ready", ready, 1);
    @(posedge clk);
    #1;
    old = m_acc;
    if (ce != 0) m_reg[wa] = wd;
    if (o == 12) m_reg[ad] = old;
    op_valid = hold[0];
    opc = hold[0] ? 4'd2 : 4'd0;
    rf_ce = 0;
    if (o == 11) begin
      for (int c = 0; c < W; c++) begin
        chk("mul busy", ready, 0);
        chk("mul nodone", done, 0);
        chk("mul acc hold", acc, old);
        @(posedge clk);
        #1;
      end
      p = old * b;
      m_acc = p & M; m_mh = p >> W;
      m_carry = 0; m_zero = (m_acc == 0);
    end else begin
      case (o)
        1: m_acc = b;
        2, 3: begin
          s = old + b + ((o == 3) ? m_carry : 0);
          m_carry = s >> W; m_acc = s & M;
        end
        4: begin
          m_carry = (old < b) ? 1 : 0;
          m_acc = (old - b) & M;
        end
        5, 6, 7, 8: m_acc = ref_alu(o, b);
        9: begin
          m_carry = (old >> (W - 1)) & 1;
          m_acc = (old * 2) & M;
        end
        10: begin
          m_carry = old & 1;
          m_acc = old / 2;
        end
        default: ;
      endcase
      if (o >= 1 && o <= 10) m_zero = (m_acc == 0);
    end
    op_valid = 0; opc = 0;
    chk("done", done, 1);
    chk("ready after", ready, 1);
    check_state("op");
  endtask

  task automatic check_regs_zero(input string tag);
    dl = 0; mem_en = 0;
    for (int i = 0; i < D; i++) begin
      mux_addr = A'(i);
      #1;
      chk(tag, arg, 0);
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    #12;
    chk("rst ready", ready, 1);
    chk("rst done", done, 0);
    check_state("rst");
    check_regs_zero("rst reg");
    @(negedge clk);
    rst = 0;

    do_op(1, 1, 0, 'hF0, 0, 0, 0, 0, 0, 0);
    do_op(2, 1, 0, 'h20, 0, 0, 0, 0, 0, 0);
    chk("add acc", acc, 'h10);
    chk("add carry", carry, 1);
    chk("add zero", zero, 0);

    do_op(1, 1, 0, 'h05, 0, 0, 0, 0, 0, 0);
    do_op(4, 1, 0, 'h05, 0, 0, 0, 0, 0, 0);
    chk("sub acc", acc, 0);
    chk("sub zero", zero, 1);
    chk("sub carry", carry, 0);
    do_op(4, 1, 0, 'h01, 0, 0, 0, 0, 0, 0);
    chk("borrow acc", acc, 'hFF);
    chk("borrow carry", carry, 1);

    do_op(1, 1, 0, 'hC8, 0, 0, 0, 0, 0, 0);
    do_op(11, 1, 0, 'h0A, 0, 0, 0, 0, 0, 1);
    chk("mul acc", acc, 'hD0);
    chk("mul high", mh, 'h07);
    @(posedge clk);
    #1;
    chk("mul done pulse", done, 0);

    do_op(1, 1, 0, 'h3C, 0, 0, 0, 0, 0, 0);
    do_op(12, 0, 0, 0, 0, 2, 1, 2, 'h99, 0);
    do_op(12, 0, 0, 0, 0, 3, 1, 4, 'h55, 0);
    do_op(1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    chk("ext wr", acc, 'h55);
    do_op(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    chk("store wins", acc, 'h3C);

    do_op(1, 1, 0, 'h07, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    op_valid = 1; opc = 4'd11; dl = 1; imm = 8'h03;
    @(posedge clk);
    #1;
    op_valid = 0; opc = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    check_state("abort");
    check_regs_zero("abort reg");
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("post rst ready", ready, 1);
    chk("post rst done", done, 0);
    chk("post rst acc", acc, 0);

    for (int n = 0; n < 300; n++) begin
      do_op($urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, M),
            $urandom_range(0, M), $urandom_range(0, D - 1),
            $urandom_range(0, 1), $urandom_range(0, D - 1),
            $urandom_range(0, M), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
